// File: rtl/dds_sine_gen.sv
// dds_sine_gen: numerically controlled oscillator for the synth voice path.
// A 32-bit phase accumulator advances by ADDER every clock. The top 2 + N
// phase bits select a quadrant and an angle into a quarter-wave sine table.
// The table is built at elaboration time, so it folds to constants.
// out_sine is a registered signed sample and lags DDS by exactly one clock.
module dds_sine_gen #(
    parameter int N = 7
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic        [31:0] ADDER,
    output logic        [31:0] DDS,
    output logic signed [31:0] out_sine
);

    localparam int ROM_DEPTH = (1 << N) + 1;
    localparam logic [N:0] QUARTER = (N + 1)'(1 << N);

    // pi in unsigned Q60 fixed point (hex expansion 3.243F6A8885A308D...).
    localparam logic [127:0] PI_Q60 = 128'h3243_F6A8_885A_308D;
    localparam logic [127:0] HALF_Q60 = 128'd1 << 59;

    // round((2^31-1) * sin(pi*k / 2^(N+1))) for 0 <= k <= 2^N.
    // A Taylor series in Q60 keeps the accumulated error far below 1 LSB of
    // the 31-bit result, so the final round-half-up is exact.
    function automatic logic [31:0] sine_q31(input int k);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] sum_pos;
        logic [127:0] sum_neg;
        logic [127:0] scaled;
        x       = (PI_Q60 * 128'(unsigned'(k))) >> (N + 1);
        x2      = (x * x) >> 60;
        term    = x;
        sum_pos = x;
        sum_neg = '0;
        for (int n = 1; n <= 12; n++) begin
            term = ((term * x2) >> 60) / 128'(unsigned'((2 * n) * (2 * n + 1)));
            if ((n % 2) == 1) begin
                sum_neg = sum_neg + term;
            end else begin
                sum_pos = sum_pos + term;
            end
        end
        scaled = (sum_pos - sum_neg) * 128'(32'h7FFF_FFFF);
        scaled = (scaled + HALF_Q60) >> 60;
        return scaled[31:0];
    endfunction

    // Applies the quadrant sign. The table magnitude never exceeds 2^31-1,
    // so the two's-complement negation cannot overflow.
    function automatic logic signed [31:0] apply_sign(input logic [31:0] mag,
                                                      input logic        neg);
        logic signed [31:0] s;
        s = signed'(mag);
        return neg ? -s : s;
    endfunction

    logic [31:0] rom [0:ROM_DEPTH-1];

    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        localparam logic [31:0] ENTRY = sine_q31(k);
        assign rom[k] = ENTRY;
    end

    logic        [31:0] phase_p0;
    logic        [1:0]  quad_p0;
    logic        [N-1:0] angle_p0;
    logic        [N:0]  addr_p0;
    logic        [31:0] mag_p0;
    logic signed [31:0] sine_p0;
    logic signed [31:0] sine_p1;

    // ---- stage p0: phase register and combinational quarter-wave lookup ----
    assign quad_p0  = phase_p0[31:30];
    assign angle_p0 = phase_p0[29:30-N];

    // Odd quadrants read the table mirrored (128 - a); quadrants 2 and 3 negate.
    assign addr_p0 = quad_p0[0] ? (QUARTER - {1'b0, angle_p0}) : {1'b0, angle_p0};
    assign mag_p0  = rom[addr_p0];
    assign sine_p0 = apply_sign(mag_p0, quad_p0[1]);

    // Accumulate phase and register the sample derived from the previous phase.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            phase_p0 <= '0;
            sine_p1  <= '0;
        end else begin
            phase_p0 <= phase_p0 + ADDER;
            sine_p1  <= sine_p0;
        end
    end

    // ---- stage p1: registered outputs ----
    assign DDS      = phase_p0;
    assign out_sine = sine_p1;

endmodule

// File: tb/tb_dds_sine_gen.sv
// Scoreboard bench for dds_sine_gen: the stimulus process pushes the expected
// DDS/out_sine pair for each edge; a monitor pops and compares after each edge.
module tb_dds_sine_gen;

    localparam logic signed [31:0] FS = 32'sd2147483647;
    localparam real PI = 3.14159265358979323846;

    logic               CLK = 1'b0;
    logic               RESET;
    logic        [31:0] ADDER;
    logic        [31:0] DDS;
    logic signed [31:0] out_sine;

    typedef struct {
        logic        [31:0] dds;
        logic signed [31:0] sine;
        string              tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] m_dds = '0;

    dds_sine_gen #(.N(7)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ADDER    (ADDER),
        .DDS      (DDS),
        .out_sine (out_sine)
    );

    always #5 CLK = ~CLK;

    // Quarter-wave table entry straight from the formula.
    function automatic int tval(input int k);
        real v;
        v = 2147483647.0 * $sin(PI * k / 256.0);
        return $rtoi($floor(v + 0.5));
    endfunction

    // Hand-computed samples at the quadrant boundaries.
    function automatic bit hand_sine(input logic [31:0] p, output logic signed [31:0] v);
        v = 32'sd0;
        case (p)
            32'h0000_0000: begin v = 32'sd0; return 1'b1; end
            32'h4000_0000: begin v = FS;     return 1'b1; end
            32'h8000_0000: begin v = 32'sd0; return 1'b1; end
            32'hC000_0000: begin v = -FS;    return 1'b1; end
            default:       return 1'b0;
        endcase
    endfunction

    function automatic logic signed [31:0] expect_sine(input logic [31:0] p);
        logic signed [31:0] hv;
        logic [1:0] q;
        int a;
        int k;
        int t;
        if (hand_sine(p, hv)) return hv;
        q = p[31:30];
        a = int'(p[29:23]);
        k = q[0] ? (128 - a) : a;
        t = tval(k);
        return q[1] ? -t : t;
    endfunction

    // Drive one edge's inputs and queue what the DUT must show after that edge.
    task automatic step(input logic r, input logic [31:0] add, input string tag);
        exp_t e;
        RESET = r;
        ADDER = add;
        if (!r) begin
            e.dds  = 32'h0;
            e.sine = 32'sd0;
        end else begin
            e.dds  = m_dds + add;
            e.sine = expect_sine(m_dds);
        end
        e.tag = tag;
        m_dds = e.dds;
        sb.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Monitor: output is valid every cycle, so compare one entry per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (DDS !== e.dds || out_sine !== e.sine) begin
                    n_bad++;
                    $display("FAIL %s: got DDS=%h out_sine=%0d, required DDS=%h out_sine=%0d",
                             e.tag, DDS, out_sine, e.dds, e.sine);
                end
            end
        end
    end

    initial begin
        RESET = 1'b0;
        ADDER = 32'd100000;

        // 1: held in reset
        for (int i = 0; i < 10; i++) step(1'b0, 32'd100000, "reset_hold");

        // 2: slow sweep, then a mid-run tuning change
        for (int i = 0; i < 20; i++) step(1'b1, 32'd100000, "adder_100000");
        for (int i = 0; i < 6; i++) step(1'b1, 32'h1234_5678, "adder_change");

        // 3: quarter-turn steps
        step(1'b0, 32'h4000_0000, "reset_q");
        for (int i = 0; i < 9; i++) step(1'b1, 32'h4000_0000, "quarter_step");

        // 4: one ROM step per clock over more than a full period
        step(1'b0, 32'h0080_0000, "reset_sweep");
        for (int i = 0; i < 520; i++) step(1'b1, 32'h0080_0000, "rom_sweep");

        // 5: maximum increment wraps backwards
        step(1'b0, 32'hFFFF_FFFF, "reset_wrap");
        for (int i = 0; i < 8; i++) step(1'b1, 32'hFFFF_FFFF, "wrap_ffffffff");

        // 6: single-cycle reset mid-sweep
        for (int i = 0; i < 8; i++) step(1'b1, 32'd100000, "pre_reset");
        step(1'b0, 32'd100000, "mid_reset");
        for (int i = 0; i < 8; i++) step(1'b1, 32'd100000, "post_reset");

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge CLK);
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
